// File: rtl/vga_fb_arbiter_if.sv
// Framebuffer bus bundle: the CPU-side write request channel plus the
// single-port memory strobe/data lines shared by writes and display reads.
interface vga_fb_arbiter_if;
  logic        wr_req;
  logic [19:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        mem_en;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // The arbiter takes the slave view; the bus master and memory sit on the other side.
  modport master (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: shares one memory port between bus writes
// and a display prefetch FIFO, favouring reads only when the FIFO runs low.
module vga_fb_arbiter #(
  parameter int FIFO_DEPTH  = 8,
  parameter int LOW_WM      = 2,
  parameter int FRAME_WORDS = 307200
) (
  input  logic              clock,
  input  logic              reset,
  vga_fb_arbiter_if.slave   bus,
  input  logic              frame_start,
  input  logic              pix_rd,
  output logic [23:0]       pix_data,
  output logic              underflow
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LOW_WM_C  = (AW+1)'(LOW_WM);
  localparam logic [19:0] LAST_ADDR = 20'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t        state, state_next;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, fill;
  logic          rd_pending;
  logic [19:0]   fetch_addr;
  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic          can_read, urgent, rd_grant, wr_grant, push, pop;
  logic          unused_rdata_bits;

  assign unused_rdata_bits = ^bus.mem_rdata[31:24];

  // Grant logic is gated by reset so the memory port stays quiet while held in reset.
  always_comb begin
    fill     = count + {{AW{1'b0}}, rd_pending};
    can_read = (state == FETCH) && !frame_start && (fill < DEPTH_C);
    urgent   = can_read && (fill <= LOW_WM_C);
    rd_grant = reset && (urgent || (can_read && !bus.wr_req));
    wr_grant = reset && bus.wr_req && !urgent;
    push     = rd_pending && !frame_start;
    pop      = pix_rd && (count != '0) && !frame_start;
  end

  assign bus.mem_en    = rd_grant || wr_grant;
  assign bus.mem_we    = wr_grant;
  assign bus.mem_addr  = rd_grant ? fetch_addr : (wr_grant ? bus.wr_addr : '0);
  assign bus.mem_wdata = wr_grant ? bus.wr_data : '0;
  assign bus.wr_ack    = wr_grant;

  assign pix_data = (count != '0) ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (frame_start)
      state_next = FETCH;
    else if ((state == FETCH) && rd_grant && (fetch_addr == LAST_ADDR))
      state_next = DONE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_pending <= 1'b0;
      fetch_addr <= '0;
      underflow  <= 1'b0;
    end else if (frame_start) begin
      // Flush: the word returning this cycle (if any) is dropped with the old frame.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_pending <= 1'b0;
      fetch_addr <= '0;
      underflow  <= 1'b0;
    end else begin
      rd_pending <= rd_grant;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pix_rd && (count == '0)) underflow <= 1'b1;
      if (rd_grant && (fetch_addr != LAST_ADDR)) fetch_addr <= fetch_addr + 20'd1;
    end
  end

  // NOTE: the FIFO storage is not reset; count and pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_rdata[23:0];
  end

endmodule
